// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode/ALU constants and sequencer state type shared by the instruction sequencer
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// rtl/seq_timeout.sv - cycle counter that flags expiry on the LIMIT-th enabled cycle since clear
module seq_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of enabled cycles already completed, so the
    // LIMIT-th enabled cycle is the one that sees cnt == LIMIT-1
    assign expired = enable && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/wait/exec instruction sequencer; SEQ_ILLEGAL_TRAP_EN adds illegal-opcode trap
module instr_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        dec_reg_write,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
`ifdef SEQ_ILLEGAL_TRAP_EN
    output logic        trap,
`endif
    output logic        bus_err
);

    seq_state_t state, state_nxt;

    logic legal;
    logic trap_now;
    logic retire;
    logic in_wait;
    logic expired;
    logic timed_out;

    assign legal     = is_legal_opcode(instr[6:0]);
    assign in_wait   = (state == ST_WAIT);
    assign timed_out = in_wait && !imem_rsp_valid && expired;

`ifdef SEQ_ILLEGAL_TRAP_EN
    assign trap_now = (state == ST_EXEC) && !legal;
`else
    assign trap_now = 1'b0;
`endif

    // without the trap build, illegal opcodes still retire (as NOPs)
    assign retire = (state == ST_EXEC) && !trap_now;

    assign imem_req_valid = (state == ST_FETCH);
    assign imem_addr      = pc;
    assign instr_valid    = (state == ST_EXEC);
    assign rf_we          = (state == ST_EXEC) && legal && dec_reg_write;
    assign halted         = (state == ST_HALT);

    seq_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: if (imem_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_EXEC;
                end else if (expired) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_EXEC:  state_nxt = (halt_req || trap_now) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
            bus_err <= 1'b0;
        end else begin
            if (in_wait && imem_rsp_valid) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc      <= pc + 32'd4;
                retired <= retired + 32'd1;
            end
            if (timed_out) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap <= 1'b0;
        end else if (trap_now) begin
            trap <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        dec_reg_write;

    logic        imem_req_valid, instr_valid, rf_we, halted, bus_err;
    logic [31:0] imem_addr, instr, pc, retired;
    logic        w_imem_req_valid, w_instr_valid, w_rf_we, w_halted, w_bus_err;
    logic [31:0] w_imem_addr, w_instr, w_pc, w_retired;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic        trap, w_trap;
`endif

    int checks;
    int failures;

    instr_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .dec_reg_write  (dec_reg_write),
        .rf_we          (rf_we),
        .pc             (pc),
        .retired        (retired),
        .halted         (halted),
`ifdef SEQ_ILLEGAL_TRAP_EN
        .trap           (trap),
`endif
        .bus_err        (bus_err)
    );

    instr_sequencer #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .imem_req_valid (w_imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (w_imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr          (w_instr),
        .instr_valid    (w_instr_valid),
        .dec_reg_write  (dec_reg_write),
        .rf_we          (w_rf_we),
        .pc             (w_pc),
        .retired        (w_retired),
        .halted         (w_halted),
`ifdef SEQ_ILLEGAL_TRAP_EN
        .trap           (w_trap),
`endif
        .bus_err        (w_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        dec_reg_write  = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Walks one instruction from FETCH through EXEC and leaves the bench in the cycle after EXEC.
    task automatic run_instr(input logic [31:0] word, input logic halt_in_exec);
        imem_req_ready = 1'b1;
        halt_req       = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rdata     = word;
        tick();
        imem_rsp_valid = 1'b0;
        halt_req       = halt_in_exec;
        tick();
        halt_req       = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", imem_req_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", imem_req_valid); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_pc_wrap got=%h exp=fffffffc", w_pc); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (retired !== 32'h0) begin failures++; $display("FAIL rst_retired got=%h exp=0", retired); end
        checks++; if ({instr_valid, rf_we, halted, bus_err} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {instr_valid, rf_we, halted, bus_err}); end
        do_reset();
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_basic();
        do_reset();
        start          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL basic_fetch got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_valid got=%b exp=0", imem_req_valid); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL basic_wait_rfwe got=%b exp=0", rf_we); end
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0050_0093;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_exec_valid got=%b exp=1", instr_valid); end
        checks++; if (instr !== 32'h0050_0093) begin failures++; $display("FAIL basic_instr got=%h exp=00500093", instr); end
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL basic_rfwe got=%b exp=1", rf_we); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL basic_exec_pc got=%h exp=0", pc); end
        tick();
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL basic_pc got=%h exp=4", pc); end
        checks++; if (retired !== 32'h1) begin failures++; $display("FAIL basic_retired got=%h exp=1", retired); end
        checks++; if ({instr_valid, rf_we} !== 2'b00) begin failures++; $display("FAIL basic_post_exec got=%b exp=00", {instr_valid, rf_we}); end
        checks++; if ({imem_req_valid, imem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL basic_refetch got=%b/%h exp=1/4", imem_req_valid, imem_addr); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        start = 1'b1;
        tick();
        start          = 1'b0;
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL stall_cycle%0d got=%b/%h exp=1/0", i, imem_req_valid, imem_addr); end
            tick();
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL stall_accept_valid got=%b exp=1", imem_req_valid); end
        tick();
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_accepted got=%b exp=0", imem_req_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_rsp_ignored got=%b exp=0", instr_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        start          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        checks++; if ({halted, bus_err} !== 2'b00) begin failures++; $display("FAIL tmo_wait255 got=%b exp=00", {halted, bus_err}); end
        tick();
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL tmo_bus_err got=%b exp=1", bus_err); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL tmo_halted got=%b exp=1", halted); end
        start          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0050_0093;
        for (int i = 0; i < 3; i++) tick();
        start          = 1'b0;
        imem_rsp_valid = 1'b0;
        checks++; if ({halted, bus_err, imem_req_valid, instr_valid} !== 4'b1100) begin failures++; $display("FAIL tmo_sticky got=%b exp=1100", {halted, bus_err, imem_req_valid, instr_valid}); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL tmo_instr got=%h exp=0", instr); end
    endtask

    task automatic test_illegal();
        do_reset();
        start = 1'b1;
        tick();
        start          = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0000_006F;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if ({instr_valid, rf_we} !== 2'b10) begin failures++; $display("FAIL ill_exec got=%b exp=10", {instr_valid, rf_we}); end
        tick();
`ifdef SEQ_ILLEGAL_TRAP_EN
        checks++; if (trap !== 1'b1) begin failures++; $display("FAIL ill_trap got=%b exp=1", trap); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL ill_pc got=%h exp=0", pc); end
        checks++; if ({halted, retired} !== {1'b1, 32'h0}) begin failures++; $display("FAIL ill_halt got=%b/%h exp=1/0", halted, retired); end
`else
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL ill_pc got=%h exp=4", pc); end
        checks++; if (retired !== 32'h1) begin failures++; $display("FAIL ill_retired got=%h exp=1", retired); end
        checks++; if ({imem_req_valid, halted} !== 2'b10) begin failures++; $display("FAIL ill_continue got=%b exp=10", {imem_req_valid, halted}); end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_instr(32'h0050_0093, 1'b0);
        checks++; if ({halted, imem_req_valid} !== 2'b01) begin failures++; $display("FAIL halt_ignored got=%b exp=01", {halted, imem_req_valid}); end
        run_instr(32'h0020_80B3, 1'b1);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
        checks++; if (retired !== 32'h2) begin failures++; $display("FAIL halt_retired got=%h exp=2", retired); end
        checks++; if (pc !== 32'h8) begin failures++; $display("FAIL halt_pc got=%h exp=8", pc); end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_no_fetch%0d got=%b exp=0", i, imem_req_valid); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        start          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (w_imem_req_valid !== 1'b0) begin failures++; $display("FAIL wrap_in_wait got=%b exp=0", w_imem_req_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_rst_pc got=%h exp=fffffffc", w_pc); end
        tick();
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        checks++; if ({w_pc, w_halted} !== {32'hFFFF_FFFC, 1'b0}) begin failures++; $display("FAIL wrap_release got=%h/%b exp=fffffffc/0", w_pc, w_halted); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({w_imem_req_valid, w_imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_fetch got=%b/%h exp=1/fffffffc", w_imem_req_valid, w_imem_addr); end
        run_instr(32'h0050_0093, 1'b0);
        checks++; if (w_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", w_pc); end
        checks++; if (w_retired !== 32'h1) begin failures++; $display("FAIL wrap_retired got=%h exp=1", w_retired); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_timeout();
        test_illegal();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before a bus error.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begins execution from IDLE.
REQ-006 SHALL have port halt_req  input  1  requests a stop after the current instruction retires.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  instruction memory accepts the request.
REQ-009 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-010 SHALL have port imem_rsp_valid  input  1  fetch data valid.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have port instr  output  32  registered instruction, driven to the decoder.
REQ-013 SHALL have port instr_valid  output  1  high for exactly the EXEC cycle.
REQ-014 SHALL have port dec_reg_write  input  1  writeback enable from the decoder.
REQ-015 SHALL have port rf_we  output  1  gated register-file write enable.
REQ-016 SHALL have port pc  output  32  current program counter.
REQ-017 SHALL have port retired  output  32  count of retired instructions.
REQ-018 SHALL have port halted  output  1  high in the HALT state.
REQ-019 SHALL have port bus_err  output  1  sticky flag set by a fetch timeout.

Function
REQ-020 SHALL implement the states IDLE, FETCH, WAIT, EXEC and HALT.
REQ-021 IDLE SHALL move to FETCH on the edge where start=1 and SHALL otherwise hold.
REQ-022 FETCH SHALL assert imem_req_valid with imem_addr=pc held stable until imem_req_ready=1, then move to WAIT.
REQ-023 WAIT SHALL latch imem_rdata into instr when imem_rsp_valid=1 and move to EXEC.
REQ-024 imem_rsp_valid SHALL be ignored in every state except WAIT.
REQ-025 The WAIT counter SHALL clear on entry to WAIT; after TIMEOUT_CYCLES cycles without a response, the block SHALL set bus_err and move to HALT.
REQ-026 EXEC SHALL last one cycle, with instr_valid=1 and rf_we=dec_reg_write for a legal opcode.
REQ-027 A legal opcode SHALL be one of 7'b0110011 or 7'b0010011.
REQ-028 On legal retire, pc SHALL be updated as pc+4, wrapping modulo 2^32.
REQ-029 On legal retire, retired SHALL increment by one, wrapping modulo 2^32.
REQ-030 After EXEC the block SHALL move to HALT if halt_req=1 in that cycle, else to FETCH; halt_req SHALL be ignored outside EXEC.
REQ-031 HALT SHALL be exited only by reset; start SHALL be ignored in HALT.
REQ-032 Fetch-to-retire latency SHALL be 1 cycle in FETCH, plus the number of WAIT cycles, plus 1 EXEC cycle.
REQ-033 rf_we SHALL be 0 in every state except EXEC.

Reset
REQ-034 Assertion of rst_n=0 SHALL force, without waiting for a clock edge: state=IDLE, pc=RESET_PC, instr=0, retired=0, bus_err=0, and all other outputs 0.
REQ-035 Reset in any state, including mid-handshake, SHALL abort the transaction, and imem_req_valid SHALL drop immediately.

Configuration
REQ-036 Macro SEQ_ILLEGAL_TRAP_EN defined: an illegal opcode in EXEC SHALL force rf_we=0, leave pc and retired unchanged, assert an output trap=1 (sticky until reset), and move to HALT.
REQ-037 Macro SEQ_ILLEGAL_TRAP_EN undefined: an illegal opcode SHALL retire as a NOP (rf_we=0, pc+4, retired+1), and the trap port SHALL be absent.

Structure
REQ-038 Package riscv_pkg SHALL hold the opcode constants OPC_RTYPE and OPC_ITYPE, the ALU opcode constants, and the sequencer state enum.
REQ-039 The WAIT timeout counter SHALL be a sub-module named seq_timeout, with inputs clear and enable and output expired.

Verification
REQ-040 Reset, then start=1; memory has ready=1 and a 1-cycle response with 32'h00500093 -> EXEC at cycle 3 with rf_we=1, then pc=4, retired=1.
REQ-041 imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr=0 stable throughout; the request is accepted on cycle 6.
REQ-042 No response for 255 WAIT cycles -> bus_err=1 and halted=1; a later start=1 has no effect.
REQ-043 Response 32'h0000006F (illegal opcode): with SEQ_ILLEGAL_TRAP_EN -> trap=1, pc=0, halted=1; without it -> rf_we=0, pc=4, fetch continues.
REQ-044 halt_req=1 during the second EXEC -> halted=1, retired=2, pc=8; no further imem_req_valid.
REQ-045 rst_n deasserted while in WAIT with RESET_PC=32'hFFFF_FFFC: after reset release, pc=32'hFFFF_FFFC; one legal retire -> pc=0 (wrap).
